aes_stream_loader: RTL and testbench

- Upstream feeder and result collector for AES_top.
- Takes 128-bit plaintext and key as 32-bit words over a valid/ready stream and assembles them into AES_data_in and AES_key_in.
- Holds AES_en high for the duration of an encryption, then captures AES_data_out into a held output register behind a valid/ready handshake.
- Sits between the bus interface and AES_top in the crypto subsystem.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_word_assembler.sv | 42 ++++
 rtl/aes_stream_loader.sv | 129 ++++++++++++
 tb/tb_aes_stream_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES stream loader.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned AES_WORD_W      = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned TCNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Collects 32-bit words into a 128-bit block, first word in the top slot.
module aes_word_assembler
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AES_WORD_W-1:0]  word,
    input  logic                   load,
    input  logic                   clear,
    output logic [AES_BLOCK_W-1:0] block,
    output logic                   full
);

    logic [WORD_IDX_W-1:0] idx;

    // Slot write, slot counter and full flag; word 0 of a new group drops full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block <= '0;
            idx   <= '0;
            full  <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                    if (idx == WORD_IDX_W'(i)) begin
                        block[AES_BLOCK_W-1-AES_WORD_W*i -: AES_WORD_W] <= word;
                    end
                end
                idx <= idx + WORD_IDX_W'(1);
                if (idx == WORD_IDX_W'(WORDS_PER_BLOCK-1)) begin
                    full <= 1'b1;
                end else if (idx == '0) begin
                    full <= 1'b0;
                end
            end
            if (clear) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// Feeds plaintext/key words into AES_top and holds the ciphertext for the consumer.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned KEY_STICKY     = 1
) (
    input  logic                   AES_clk,
    input  logic                   AES_rst_n,
    input  logic [AES_WORD_W-1:0]  s_word,
    input  logic                   s_is_key,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   AES_en,
    output logic [AES_BLOCK_W-1:0] AES_data_in,
    output logic [AES_BLOCK_W-1:0] AES_key_in,
    input  logic [AES_BLOCK_W-1:0] AES_data_out,
    input  logic                   AES_data_out_valid,
    output logic [AES_BLOCK_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    state_t                 state_q, state_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   en_d, busy_d, m_valid_d, terr_d;
    logic [AES_BLOCK_W-1:0] m_data_d;
    logic                   data_clear, key_clear;
    logic                   data_full, key_loaded;
    logic                   accept;

    // Key words only wait for RUN to end; data words also wait for a free block.
    assign s_ready = (state_q != RUN) && (s_is_key || !data_full);
    assign accept  = s_valid && s_ready;

    aes_word_assembler u_data (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .word  (s_word),
        .load  (accept && !s_is_key),
        .clear (data_clear),
        .block (AES_data_in),
        .full  (data_full)
    );

    aes_word_assembler u_key (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .word  (s_word),
        .load  (accept && s_is_key),
        .clear (key_clear),
        .block (AES_key_in),
        .full  (key_loaded)
    );

    // Next-state and next-output logic; valid beats timeout in RUN.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        en_d       = AES_en;
        busy_d     = busy;
        m_valid_d  = m_valid;
        m_data_d   = m_data;
        terr_d     = timeout_err;
        data_clear = 1'b0;
        key_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_full && key_loaded && !m_valid) begin
                    state_d = RUN;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    tcnt_d  = '0;
                    terr_d  = 1'b0;
                end
            end
            RUN: begin
                if (AES_data_out_valid) begin
                    state_d    = OUT;
                    m_data_d   = AES_data_out;
                    m_valid_d  = 1'b1;
                    en_d       = 1'b0;
                    busy_d     = 1'b0;
                    data_clear = 1'b1;
                    key_clear  = (KEY_STICKY == 0);
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    en_d       = 1'b0;
                    busy_d     = 1'b0;
                    terr_d     = 1'b1;
                    data_clear = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            AES_en      <= 1'b0;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            AES_en      <= en_d;
            busy        <= busy_d;
            m_valid     <= m_valid_d;
            m_data      <= m_data_d;
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed/randomized bench for aes_stream_loader with a simple AES_top stub.
module tb_aes_stream_loader;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n;
    logic [31:0]  s_word;
    logic         s_is_key;
    logic         s_valid;
    logic         s_ready;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out = '0;
    logic         AES_data_out_valid = 1'b0;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         busy;
    logic         timeout_err;

    int checks   = 0;
    int failures = 0;

    // Stub controls: valid after stub_delay AES_en cycles (0 = never), or a forced stray valid.
    int           stub_delay = 11;
    int           en_cnt     = 0;
    logic         stray      = 1'b0;
    logic [127:0] stray_val  = '0;

    aes_stream_loader #(.TIMEOUT_CYCLES(64), .KEY_STICKY(1)) dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .s_word             (s_word),
        .s_is_key           (s_is_key),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    always #5 AES_clk = ~AES_clk;

    // AES_top stand-in: ciphertext = data ^ key, presented on the chosen AES_en cycle.
    always @(negedge AES_clk) begin
        if (!AES_en) en_cnt = 0;
        else         en_cnt = en_cnt + 1;
        AES_data_out_valid = stray || (stub_delay != 0 && AES_en && en_cnt == stub_delay);
        AES_data_out       = stray ? stray_val : (AES_data_in ^ AES_key_in);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic k);
        int n;
        n = 0;
        @(negedge AES_clk);
        s_word = w; s_is_key = k; s_valid = 1'b1;
        #1;
        while (!s_ready && n < 200) begin
            @(negedge AES_clk); #1;
            n++;
        end
        if (n >= 200) check("ready_wait", 0, 1);
        @(posedge AES_clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] v, input logic k);
        for (int i = 0; i < 4; i++) send_word(v[127-32*i -: 32], k);
    endtask

    // Cycles until AES_en is seen high (sampled 1ns after each edge).
    task automatic wait_launch(output int n);
        n = 0;
        do begin
            @(posedge AES_clk); #1;
            n++;
        end while (!AES_en && n < 300);
        if (!AES_en) check("launch_wait", 0, 1);
    endtask

    // Counts AES_en-high cycles after a launch, ending on the edge AES_en falls.
    task automatic count_en(output int n);
        n = 1;
        while (n < 300) begin
            @(posedge AES_clk); #1;
            if (!AES_en) break;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge AES_clk);
        m_ready = 1'b1;
        @(posedge AES_clk); #1;
        check("m_valid_drop", m_valid, 0);
        m_ready = 1'b0;
    endtask

    logic [127:0] key_m, d, held;
    int n;
    int rose;

    initial begin
        AES_rst_n = 1'b0; s_word = '0; s_is_key = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge AES_clk);
        #1;
        check("rst_en", AES_en, 0);
        check("rst_data_in", AES_data_in, 0);
        check("rst_key_in", AES_key_in, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_s_ready", s_ready, 1);
        @(negedge AES_clk);
        AES_rst_n = 1'b1;

        // Known-answer block with 1-cycle launch latency and 11-cycle stub.
        key_m = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
        d     = 128'h0000009f_00000000_00000000_00000000;
        send_block(key_m, 1'b1);
        send_block(d, 1'b0);
        check("pre_launch_en", AES_en, 0);
        wait_launch(n);
        check("launch_latency", n, 1);
        check("run_busy", busy, 1);
        check("run_data_in", AES_data_in, d);
        check("run_data_blocked", s_ready, 0);
        count_en(n);
        check("kat_en_cycles", n, 11);
        check("kat_m_valid", m_valid, 1);
        check("kat_m_data", m_data, 128'haa2bdbdf_bff6a5e8_caa9ba3e_bc1e2acc);
        check("kat_busy_low", busy, 0);
        consume();

        // Sticky key: second block without reloading the key.
        d = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
        send_block(d, 1'b0);
        wait_launch(n);
        check("sticky_latency", n, 1);
        check("sticky_key_in", AES_key_in, key_m);
        count_en(n);
        check("sticky_m_data", m_data, d ^ key_m);
        held = d ^ key_m;

        // Back-pressure: load a random block in OUT while m_ready stays low.
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        check("overlap_data_in", AES_data_in, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge AES_clk);
            check("hold_m_valid", m_valid, 1);
            check("hold_m_data", m_data, held);
            check("hold_no_en", AES_en, 0);
            check("hold_data_blocked", s_ready, 0);
        end
        @(negedge AES_clk);
        m_ready = 1'b1;
        @(posedge AES_clk); #1;
        m_ready = 1'b0;
        check("handshake_m_valid", m_valid, 0);
        check("handshake_no_en", AES_en, 0);
        wait_launch(n);
        check("relaunch_latency", n, 1);
        count_en(n);
        check("relaunch_m_data", m_data, d ^ key_m);
        held = d ^ key_m;
        consume();

        // Timeout: stub never answers.
        stub_delay = 0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        wait_launch(n);
        count_en(n);
        check("timeout_en_cycles", n, 64);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_m_valid", m_valid, 0);
        check("timeout_m_data", m_data, held);
        check("timeout_busy", busy, 0);
        check("timeout_idle_ready", s_ready, 1);

        // Next good launch clears the error.
        stub_delay = 11;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        wait_launch(n);
        check("terr_cleared", timeout_err, 0);
        count_en(n);
        check("after_to_m_data", m_data, d ^ key_m);
        consume();

        // Valid on the timeout cycle: capture wins.
        stub_delay = 64;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        wait_launch(n);
        count_en(n);
        check("tie_en_cycles", n, 64);
        check("tie_m_valid", m_valid, 1);
        check("tie_terr", timeout_err, 0);
        check("tie_m_data", m_data, d ^ key_m);
        held = d ^ key_m;
        consume();

        // Stray valid in IDLE is ignored.
        stray_val = {$urandom, $urandom, $urandom, $urandom};
        stray = 1'b1;
        repeat (3) @(posedge AES_clk);
        #1;
        stray = 1'b0;
        check("stray_m_data", m_data, held);
        check("stray_m_valid", m_valid, 0);
        check("stray_en", AES_en, 0);

        // Reset mid-RUN, then a full reload is required.
        stub_delay = 0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        wait_launch(n);
        repeat (5) @(posedge AES_clk);
        @(negedge AES_clk);
        #2 AES_rst_n = 1'b0;
        #1;
        check("arst_en", AES_en, 0);
        check("arst_busy", busy, 0);
        check("arst_m_valid", m_valid, 0);
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        #1;
        check("arst_s_ready", s_ready, 1);
        check("arst_key_in", AES_key_in, 0);
        d = {$urandom, $urandom, $urandom, $urandom};
        send_block(d, 1'b0);
        rose = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge AES_clk); #1;
            if (AES_en) rose = 1;
        end
        check("no_key_no_launch", rose, 0);
        stub_delay = 11;
        key_m = {$urandom, $urandom, $urandom, $urandom};
        send_block(key_m, 1'b1);
        wait_launch(n);
        check("key_launch_latency", n, 1);
        check("reload_key_in", AES_key_in, key_m);
        check("reload_data_in", AES_data_in, d);
        count_en(n);
        check("reload_m_data", m_data, d ^ key_m);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
